// File: rtl/mul4_fitness_sequencer.sv
// Fitness sequencer for a combinational mul4 candidate: drives LFSR operand vectors and counts
// 16-bit product lanes that match the golden 32x32 product. Option: MUL4_CORNER_VECTORS_EN.
`timescale 1ns/1ps
module mul4_fitness_sequencer #(
   parameter int unsigned NUM_VECTORS = 64,
   parameter logic [31:0] LFSR_SEED_A = 32'hACE1_1234,
   parameter logic [31:0] LFSR_SEED_B = 32'h1357_9BDF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [15:0] fitness,
   output logic        perfect,
   output logic [15:0] dut_a1,
   output logic [15:0] dut_a0,
   output logic [15:0] dut_b1,
   output logic [15:0] dut_b0,
   input  logic [15:0] dut_y3,
   input  logic [15:0] dut_y2,
   input  logic [15:0] dut_y1,
   input  logic [15:0] dut_y0
);

   localparam logic [31:0] Taps = 32'h8020_0003;
   localparam int unsigned IdxW = 14;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VECTORS - 1);
   localparam logic [15:0] FullScore = 16'(4 * NUM_VECTORS);

   typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [31:0]       lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
   logic [31:0]       op_a_q, op_a_d, op_b_q, op_b_d;
   logic [15:0]       fitness_q, fitness_d;
   logic              perfect_q, perfect_d;

   logic              load;
   logic [31:0]       src_a, src_b;
   logic [31:0]       vec_a, vec_b, nxt_a, nxt_b;
   logic [63:0]       golden;
   logic [2:0]        hits;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? Taps : 32'h0);
   endfunction

   assign golden = {32'h0, op_a_q} * {32'h0, op_b_q};
   assign hits   = 3'(dut_y0 == golden[15:0])  + 3'(dut_y1 == golden[31:16]) +
                   3'(dut_y2 == golden[47:32]) + 3'(dut_y3 == golden[63:48]);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      fitness_d = fitness_q;
      perfect_d = perfect_q;
      load      = 1'b0;
      src_a     = lfsr_a_q;
      src_b     = lfsr_b_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               fitness_d = '0;
               perfect_d = 1'b0;
               idx_d     = '0;
               load      = 1'b1;
               src_a     = LFSR_SEED_A;
               src_b     = LFSR_SEED_B;
               state_d   = StDrive;
            end
         end
         StDrive: state_d = StSample;
         StSample: begin
            fitness_d = fitness_q + {13'h0, hits};
            if (idx_q == LastIdx) begin
               // Registered here so perfect is already valid during the done cycle.
               perfect_d = (fitness_d == FullScore);
               state_d   = StDone;
            end else begin
               idx_d   = idx_q + 1'b1;
               load    = 1'b1;
               state_d = StDrive;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

`ifdef MUL4_CORNER_VECTORS_EN
   // Corner vectors occupy indices 0..3 and leave the LFSRs untouched.
   always_comb begin
      vec_a = src_a;
      vec_b = src_b;
      nxt_a = lfsr_step(src_a);
      nxt_b = lfsr_step(src_b);
      if (idx_d < IdxW'(4)) begin
         nxt_a = src_a;
         nxt_b = src_b;
         unique case (idx_d[1:0])
            2'd0: begin vec_a = 32'h0000_0000; vec_b = 32'h0000_0000; end
            2'd1: begin vec_a = 32'hFFFF_FFFF; vec_b = 32'hFFFF_FFFF; end
            2'd2: begin vec_a = 32'h0000_0001; vec_b = 32'hFFFF_FFFF; end
            2'd3: begin vec_a = 32'h0001_0000; vec_b = 32'h0001_0000; end
            default: ;
         endcase
      end
   end
`else
   always_comb begin
      vec_a = src_a;
      vec_b = src_b;
      nxt_a = lfsr_step(src_a);
      nxt_b = lfsr_step(src_b);
   end
`endif

   always_comb begin
      op_a_d   = load ? vec_a : op_a_q;
      op_b_d   = load ? vec_b : op_b_q;
      lfsr_a_d = load ? nxt_a : lfsr_a_q;
      lfsr_b_d = load ? nxt_b : lfsr_b_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         lfsr_a_q  <= LFSR_SEED_A;
         lfsr_b_q  <= LFSR_SEED_B;
         op_a_q    <= '0;
         op_b_q    <= '0;
         fitness_q <= '0;
         perfect_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         lfsr_a_q  <= lfsr_a_d;
         lfsr_b_q  <= lfsr_b_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         fitness_q <= fitness_d;
         perfect_q <= perfect_d;
      end
   end

   assign busy    = (state_q == StDrive) || (state_q == StSample);
   assign done    = (state_q == StDone);
   assign fitness = fitness_q;
   assign perfect = perfect_q;
   assign dut_a1  = op_a_q[31:16];
   assign dut_a0  = op_a_q[15:0];
   assign dut_b1  = op_b_q[31:16];
   assign dut_b0  = op_b_q[15:0];

endmodule

// File: tb/tb_mul4_fitness_sequencer.sv
// Scoreboard bench: three sequencers (ideal, echo and stuck-zero candidates) checked against a
// local LFSR/product model of the expected operand stream and fitness.
`timescale 1ns/1ps
module tb_mul4_fitness_sequencer;

   localparam logic [31:0] SeedA = 32'hACE1_1234;
   localparam logic [31:0] SeedB = 32'h1357_9BDF;
   localparam logic [31:0] Taps  = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start [3];
   logic        busy [3];
   logic        done [3];
   logic        perfect [3];
   logic [15:0] fitness [3];
   logic [15:0] a1 [3];
   logic [15:0] a0 [3];
   logic [15:0] b1 [3];
   logic [15:0] b0 [3];
   logic [15:0] y3 [3];
   logic [15:0] y2 [3];
   logic [15:0] y1 [3];
   logic [15:0] y0 [3];

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q [$];

   always #5 clk = ~clk;

   function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
      return {32'h0, a} * {32'h0, b};
   endfunction

   // 0: ideal multiplier, 1: echoes A into the low lanes, 2: all lanes stuck at zero
   function automatic logic [63:0] cand(input int d, input logic [31:0] a, input logic [31:0] b);
      case (d)
         0:       return golden(a, b);
         1:       return {32'h0, a};
         default: return 64'h0;
      endcase
   endfunction

   function automatic int lane_hits(input logic [63:0] y, input logic [63:0] g);
      int h = 0;
      for (int k = 0; k < 4; k++) if (y[16*k +: 16] == g[16*k +: 16]) h++;
      return h;
   endfunction

   function automatic int nv(input int d);
      case (d)
         0:       return 64;
         1:       return 1;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? Taps : 32'h0);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cand
      logic [63:0] yv;
      assign yv    = cand(g, {a1[g], a0[g]}, {b1[g], b0[g]});
      assign y3[g] = yv[63:48];
      assign y2[g] = yv[47:32];
      assign y1[g] = yv[31:16];
      assign y0[g] = yv[15:0];
   end

   mul4_fitness_sequencer #(.NUM_VECTORS(64), .LFSR_SEED_A(SeedA), .LFSR_SEED_B(SeedB)) u0 (
      .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .fitness(fitness[0]), .perfect(perfect[0]),
      .dut_a1(a1[0]), .dut_a0(a0[0]), .dut_b1(b1[0]), .dut_b0(b0[0]),
      .dut_y3(y3[0]), .dut_y2(y2[0]), .dut_y1(y1[0]), .dut_y0(y0[0]));

   mul4_fitness_sequencer #(.NUM_VECTORS(1), .LFSR_SEED_A(SeedA), .LFSR_SEED_B(SeedB)) u1 (
      .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .fitness(fitness[1]), .perfect(perfect[1]),
      .dut_a1(a1[1]), .dut_a0(a0[1]), .dut_b1(b1[1]), .dut_b0(b0[1]),
      .dut_y3(y3[1]), .dut_y2(y2[1]), .dut_y1(y1[1]), .dut_y0(y0[1]));

   mul4_fitness_sequencer #(.NUM_VECTORS(4), .LFSR_SEED_A(SeedA), .LFSR_SEED_B(SeedB)) u2 (
      .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .fitness(fitness[2]), .perfect(perfect[2]),
      .dut_a1(a1[2]), .dut_a0(a0[2]), .dut_b1(b1[2]), .dut_b0(b0[2]),
      .dut_y3(y3[2]), .dut_y2(y2[2]), .dut_y1(y1[2]), .dut_y0(y0[2]));

   // Entered from an idle cycle; returns sampling the idle cycle after done.
   task automatic run_eval(input int d, input bit hold, input bit noisy, output int fit_seen);
      logic [31:0] la, lb, va, vb;
      logic [63:0] v, last_v;
      int n, exp_fit;
      n = nv(d);
      la = SeedA;
      lb = SeedB;
      exp_fit = 0;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
`ifdef MUL4_CORNER_VECTORS_EN
         if (i < 4) begin
            case (i)
               0:       begin va = 32'h0000_0000; vb = 32'h0000_0000; end
               1:       begin va = 32'hFFFF_FFFF; vb = 32'hFFFF_FFFF; end
               2:       begin va = 32'h0000_0001; vb = 32'hFFFF_FFFF; end
               default: begin va = 32'h0001_0000; vb = 32'h0001_0000; end
            endcase
         end else begin
            va = la; vb = lb; la = step(la); lb = step(lb);
         end
`else
         va = la; vb = lb; la = step(la); lb = step(lb);
`endif
         exp_q.push_back({va, vb});
         exp_fit += lane_hits(cand(d, va, vb), golden(va, vb));
      end
      last_v = exp_q[n-1];
      @(negedge clk);
      start[d] = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 2*n + 1; c++) begin
         #1;
         total++;
         if ({busy[d], done[d]} !== {c <= 2*n, c == 2*n + 1}) begin
            bad++;
            $display("FAIL busy_done d=%0d cyc=%0d got=%b%b want=%b%b", d, c, busy[d], done[d],
                     c <= 2*n, c == 2*n + 1);
         end
         if (c == 1) begin
            total++;
            if (fitness[d] !== 16'h0 || perfect[d] !== 1'b0) begin
               bad++;
               $display("FAIL start_clear d=%0d got=%0d/%b want=0/0", d, fitness[d], perfect[d]);
            end
         end
         if ((c % 2) == 1 && c < 2*n + 1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_empty d=%0d cyc=%0d got=empty want=vector", d, c);
            end else begin
               v = exp_q.pop_front();
               if ({a1[d], a0[d], b1[d], b0[d]} !== v) begin
                  bad++;
                  $display("FAIL operands d=%0d vec=%0d got=%h want=%h", d, c / 2,
                           {a1[d], a0[d], b1[d], b0[d]}, v);
               end
            end
         end
         if (c == 2*n + 1) begin
            total++;
            if (fitness[d] !== 16'(exp_fit) || perfect[d] !== (exp_fit == 4*n)) begin
               bad++;
               $display("FAIL final d=%0d got=%0d/%b want=%0d/%b", d, fitness[d], perfect[d],
                        exp_fit, exp_fit == 4*n);
            end
         end
         start[d] = hold ? 1'b1 : (noisy && c < 2*n + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (c < 2*n + 1) @(posedge clk);
      end
      fit_seen = int'(fitness[d]);
      @(posedge clk);
      #1;
      total++;
      if (busy[d] !== 1'b0 || done[d] !== 1'b0 || fitness[d] !== 16'(exp_fit) ||
          {a1[d], a0[d], b1[d], b0[d]} !== last_v) begin
         bad++;
         $display("FAIL idle_hold d=%0d got=%b%b %0d %h want=00 %0d %h", d, busy[d], done[d],
                  fitness[d], {a1[d], a0[d], b1[d], b0[d]}, exp_fit, last_v);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) start[i] = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         total++;
         if (busy[d] !== 1'b0 || done[d] !== 1'b0 || fitness[d] !== 16'h0 ||
             perfect[d] !== 1'b0 || {a1[d], a0[d], b1[d], b0[d]} !== 64'h0) begin
            bad++;
            $display("FAIL reset d=%0d got=%b%b %0d %b %h want=00 0 0 0", d, busy[d], done[d],
                     fitness[d], perfect[d], {a1[d], a0[d], b1[d], b0[d]});
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_ideal();
      int f;
      run_eval(0, 1'b0, 1'b0, f);
      total++;
      if (f != 256) begin
         bad++;
         $display("FAIL ideal_score got=%0d want=256", f);
      end
   endtask

   task automatic test_stuck_zero();
      int f;
      run_eval(2, 1'b0, 1'b0, f);
`ifdef MUL4_CORNER_VECTORS_EN
      total++;
      if (f != 10) begin
         bad++;
         $display("FAIL corner_score got=%0d want=10", f);
      end
`endif
   endtask

   task automatic test_echo();
      int f;
      run_eval(1, 1'b0, 1'b0, f);
   endtask

   task automatic test_back_to_back();
      int f1, f2;
      run_eval(0, 1'b1, 1'b0, f1);
      run_eval(0, 1'b0, 1'b0, f2);
      total++;
      if (f1 != f2) begin
         bad++;
         $display("FAIL repeat_score got=%0d want=%0d", f2, f1);
      end
   endtask

   task automatic test_start_noise();
      int f;
      run_eval(0, 1'b0, 1'b1, f);
   endtask

   task automatic test_reset_abort();
      int f;
      @(negedge clk);
      start[0] = 1'b1;
      @(posedge clk);
      #1;
      start[0] = 1'b0;
      repeat (21) @(posedge clk);
      #1;
      total++;
      if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
         bad++;
         $display("FAIL pre_abort got=%b%b want=10", busy[0], done[0]);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      total++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || fitness[0] !== 16'h0 || perfect[0] !== 1'b0 ||
          {a1[0], a0[0], b1[0], b0[0]} !== 64'h0) begin
         bad++;
         $display("FAIL abort got=%b%b %0d %b %h want=00 0 0 0", busy[0], done[0], fitness[0],
                  perfect[0], {a1[0], a0[0], b1[0], b0[0]});
      end
      repeat (4) begin
         @(posedge clk);
         #1;
         total++;
         if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            bad++;
            $display("FAIL abort_quiet got=%b%b want=00", busy[0], done[0]);
         end
      end
      run_eval(0, 1'b0, 1'b0, f);
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_stuck_zero();
      test_echo();
      test_back_to_back();
      test_start_noise();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
